// File: rtl/frame_burst_writer_if.sv
// Burst write channel between a frame writer (master) and one port of the
// round-robin DDR write arbiter (slave).
interface frame_burst_writer_if #(
  parameter int MEM_DATA_BITS = 32
);
  logic                     wr_burst_req;
  logic [9:0]               wr_burst_len;
  logic [26:0]              wr_burst_addr;
  logic                     wr_burst_data_req;
  logic [MEM_DATA_BITS-1:0] wr_burst_data;
  logic                     wr_burst_finish;

  modport master (
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  wr_burst_data_req, wr_burst_finish
  );

  modport slave (
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output wr_burst_data_req, wr_burst_finish
  );
endinterface

// File: rtl/frame_burst_writer.sv
// Drains a show-ahead pixel FIFO into a linear frame region in fixed-length bursts.
// Optional FRAME_BURST_WRITER_PINGPONG_EN alternates between two frame buffers.
module frame_burst_writer #(
  parameter int MEM_DATA_BITS = 32,
  parameter int BURST_LEN     = 128,
  parameter int LEVEL_BITS    = 11,
  parameter int TIMEOUT       = 10000
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic [26:0]              frame_base,
  input  logic [26:0]              frame_words,
  input  logic                     frame_start,
  input  logic [LEVEL_BITS-1:0]    fifo_level,
  input  logic [MEM_DATA_BITS-1:0] fifo_rdata,
  output logic                     fifo_rd_en,
  frame_burst_writer_if.master     bus,
  output logic                     frame_done,
  output logic                     timeout_err,
  output logic                     frame_bank
);
  localparam int          CW          = $clog2(TIMEOUT + 1);
  localparam logic [26:0] BURST_LEN_W = 27'(BURST_LEN);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_WRITE, S_END} state_e;

  state_e          state_q, state_d;
  logic [26:0]     addr_q, addr_d, remaining_q, remaining_d, burst_addr_q, burst_addr_d;
  logic [9:0]      len_q, len_d;
  logic            req_q, req_d, done_q, done_d, terr_q, terr_d;
  logic            bank_q, bank_d, pend_q, pend_d, prev_q, prev_d;
  logic [1:0]      sync_q, sync_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [9:0]      cur_len;
  logic [26:0]     rem_new, restart_addr;
  logic            lvl_ok, apply, start_edge, bank_new;

  assign start_edge = sync_q[1] & ~prev_q;
  assign apply      = pend_q && (state_q == S_IDLE || state_q == S_CHECK);
  assign cur_len    = (remaining_q < BURST_LEN_W) ? remaining_q[9:0] : BURST_LEN_W[9:0];
  assign lvl_ok     = 32'(fifo_level) >= 32'(cur_len);
  assign rem_new    = remaining_q - 27'(len_q);

`ifdef FRAME_BURST_WRITER_PINGPONG_EN
  // Second buffer sits directly after the first one.
  assign bank_new     = ~bank_q;
  assign restart_addr = frame_base + (bank_new ? frame_words : 27'd0);
`else
  assign bank_new     = 1'b0;
  assign restart_addr = frame_base;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    len_d        = len_q;
    burst_addr_d = burst_addr_q;
    req_d        = req_q;
    done_d       = 1'b0;
    terr_d       = terr_q;
    bank_d       = bank_q;
    sync_d       = {sync_q[0], frame_start};
    prev_d       = sync_q[1];
    pend_d       = pend_q | start_edge;
    cnt_d        = (state_q == S_REQ || state_q == S_WRITE) ? cnt_q + CW'(1) : '0;

    // Restarts only land between bursts, so an in-flight burst is never cut.
    if (apply) begin
      addr_d      = restart_addr;
      remaining_d = frame_words;
      bank_d      = bank_new;
      pend_d      = start_edge;
    end

    unique case (state_q)
      S_IDLE:  state_d = S_CHECK;
      S_CHECK: begin
        if (!pend_q && remaining_q != '0 && lvl_ok) begin
          len_d        = cur_len;
          burst_addr_d = addr_q;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        req_d   = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (bus.wr_burst_finish) begin
          req_d   = 1'b0;
          state_d = S_END;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          req_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_END: begin
        addr_d      = addr_q + 27'(len_q);
        remaining_d = rem_new;
        done_d      = (rem_new == '0);
        state_d     = S_CHECK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      len_q        <= '0;
      burst_addr_q <= '0;
      req_q        <= 1'b0;
      done_q       <= 1'b0;
      terr_q       <= 1'b0;
      bank_q       <= 1'b0;
      pend_q       <= 1'b0;
      prev_q       <= 1'b0;
      sync_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      len_q        <= len_d;
      burst_addr_q <= burst_addr_d;
      req_q        <= req_d;
      done_q       <= done_d;
      terr_q       <= terr_d;
      bank_q       <= bank_d;
      pend_q       <= pend_d;
      prev_q       <= prev_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.wr_burst_req  = req_q;
  assign bus.wr_burst_len  = len_q;
  assign bus.wr_burst_addr = burst_addr_q;
  assign bus.wr_burst_data = (state_q == S_WRITE) ? fifo_rdata : '0;
  assign fifo_rd_en        = (state_q == S_WRITE) & bus.wr_burst_data_req;
  assign frame_done        = done_q;
  assign timeout_err       = terr_q;
  assign frame_bank        = bank_q;
endmodule

// File: tb/tb_frame_burst_writer.sv
// Randomized bench for frame_burst_writer: emulates the FIFO and arbiter and
// checks bursts against a frame-level model of addresses, lengths and data.
module tb_frame_burst_writer;
  localparam int BURST_LEN = 128;
  localparam int TIMEOUT   = 10000;

  logic        mem_clk = 1'b0;
  logic        rst_n;
  logic [26:0] frame_base, frame_words;
  logic        frame_start;
  logic [10:0] fifo_level;
  logic [31:0] fifo_rdata;
  logic        fifo_rd_en, frame_done, timeout_err, frame_bank;

  frame_burst_writer_if #(.MEM_DATA_BITS(32)) bus ();

  frame_burst_writer #(
    .MEM_DATA_BITS(32), .BURST_LEN(BURST_LEN), .LEVEL_BITS(11), .TIMEOUT(TIMEOUT)
  ) dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .frame_base(frame_base), .frame_words(frame_words),
    .frame_start(frame_start), .fifo_level(fifo_level), .fifo_rdata(fifo_rdata),
    .fifo_rd_en(fifo_rd_en), .bus(bus), .frame_done(frame_done),
    .timeout_err(timeout_err), .frame_bank(frame_bank)
  );

  always #5 mem_clk = ~mem_clk;

  int          n_checks = 0, n_fail = 0;
  int          done_cnt = 0, req_rises = 0, exp_done = 0;
  logic        req_prev = 1'b0;
  logic        exp_bank = 1'b0;
  logic [31:0] fifo_q[$];

  always @(negedge mem_clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (bus.wr_burst_req && !req_prev) req_rises <= req_rises + 1;
    req_prev <= bus.wr_burst_req;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void fifo_sync();
    fifo_level = 11'(fifo_q.size());
    fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endfunction

  function automatic void push_words(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back($urandom);
    fifo_sync();
  endfunction

  // Restart address as seen by the frame model, including buffer alternation.
  function automatic logic [26:0] model_restart(input logic [26:0] b, input logic [26:0] w);
`ifdef FRAME_BURST_WRITER_PINGPONG_EN
    exp_bank = ~exp_bank;
    return b + (exp_bank ? w : 27'd0);
`else
    return b;
`endif
  endfunction

  task automatic pulse_start();
    frame_start = 1'b1;
    repeat (4) @(negedge mem_clk);
    frame_start = 1'b0;
    repeat (2) @(negedge mem_clk);
  endtask

  task automatic wait_req(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= bound; i++) begin
      if (bus.wr_burst_req) begin ok = 1'b1; break; end
      @(negedge mem_clk);
    end
  endtask

  // Arbiter side of one burst; restart_at >= 0 raises frame_start mid-burst.
  task automatic do_burst(input logic [26:0] ea, input logic [9:0] el, input int restart_at);
    bit ok;
    int n;
    wait_req(300, ok);
    chk("req_seen", 64'(ok), 64'd1);
    if (!ok) return;
    chk("burst_addr", 64'(bus.wr_burst_addr), 64'(ea));
    chk("burst_len", 64'(bus.wr_burst_len), 64'(el));
    repeat ($urandom_range(0, 3)) @(negedge mem_clk);
    n = 0;
    while (n < int'(el)) begin
      if (n == restart_at) frame_start = 1'b1;
      bus.wr_burst_data_req = ($urandom_range(0, 3) != 0);
      #1;
      chk("rd_en", 64'(fifo_rd_en), 64'(bus.wr_burst_data_req));
      if (bus.wr_burst_data_req) begin
        chk("data", 64'(bus.wr_burst_data), 64'(fifo_q[0]));
        void'(fifo_q.pop_front());
        fifo_sync();
        n++;
      end
      @(negedge mem_clk);
    end
    bus.wr_burst_data_req = 1'b0;
    bus.wr_burst_finish   = 1'b1;
    @(negedge mem_clk);
    bus.wr_burst_finish   = 1'b0;
    #1;
    chk("req_drop", 64'(bus.wr_burst_req), 64'd0);
  endtask

  task automatic run_bursts(input logic [26:0] a0, input logic [26:0] words);
    logic [26:0] a, rem;
    logic [9:0]  len;
    a = a0; rem = words;
    while (rem != 0) begin
      len = (rem < 27'(BURST_LEN)) ? rem[9:0] : 10'(BURST_LEN);
      do_burst(a, len, -1);
      if (rem == words) chk("frame_bank", 64'(frame_bank), 64'(exp_bank));
      a = a + 27'(len); rem = rem - 27'(len);
    end
    if (words != 0) exp_done++;
    repeat (3) @(negedge mem_clk);
    #2;
    chk("frame_done_cnt", 64'(done_cnt), 64'(exp_done));
  endtask

  initial begin
    bit          ok;
    int          r0, cnt;
    logic [26:0] a, b2;

    rst_n = 1'b0; frame_start = 1'b0;
    frame_base = '0; frame_words = '0;
    bus.wr_burst_data_req = 1'b0; bus.wr_burst_finish = 1'b0;
    fifo_sync();
    repeat (3) @(negedge mem_clk);
    #1;
    chk("rst_req", 64'(bus.wr_burst_req), 64'd0);
    chk("rst_len", 64'(bus.wr_burst_len), 64'd0);
    chk("rst_addr", 64'(bus.wr_burst_addr), 64'd0);
    chk("rst_data", 64'(bus.wr_burst_data), 64'd0);
    chk("rst_flags", 64'({fifo_rd_en, frame_done, timeout_err, frame_bank}), 64'd0);
    @(negedge mem_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge mem_clk);

    // Basic frame: 300 words in bursts of 128/128/44.
    frame_base = 27'h1000; frame_words = 27'd300;
    push_words(300);
    pulse_start();
    a = model_restart(frame_base, frame_words);
    run_bursts(a, frame_words);
    chk("fifo_drained", 64'(fifo_q.size()), 64'd0);

    // Insufficient data holds the request back until a full burst is buffered.
    frame_base = 27'($urandom); frame_words = 27'd300;
    push_words(100);
    pulse_start();
    a = model_restart(frame_base, frame_words);
    #2; r0 = req_rises;
    repeat (50) @(negedge mem_clk);
    #2;
    chk("no_req_low_level", 64'(req_rises - r0), 64'd0);
    push_words(28);
    wait_req(3, ok);
    chk("req_within_3", 64'(ok), 64'd1);
    push_words(172);
    run_bursts(a, frame_words);

    // Restart edge during a burst is deferred until the burst completes.
    frame_base = 27'($urandom); frame_words = 27'd300;
    push_words(300);
    pulse_start();
    a = model_restart(frame_base, frame_words);
    b2 = 27'($urandom);
    frame_base = b2; frame_words = 27'd200;
    do_burst(a, 10'd128, 60);
    frame_start = 1'b0;
    push_words(28);
    a = model_restart(b2, 27'd200);
    run_bursts(a, 27'd200);

    // Withheld grant times out and the identical burst is retried.
    frame_base = 27'($urandom); frame_words = 27'd128;
    push_words(128);
    pulse_start();
    a = model_restart(frame_base, frame_words);
    wait_req(50, ok);
    chk("to_req_seen", 64'(ok), 64'd1);
    chk("to_addr", 64'(bus.wr_burst_addr), 64'(a));
    cnt = 0;
    while (bus.wr_burst_req && cnt < TIMEOUT + 50) begin
      @(negedge mem_clk);
      cnt++;
    end
    chk("timeout_window", 64'(cnt >= TIMEOUT - 5 && cnt <= TIMEOUT + 5), 64'd1);
    chk("timeout_err", 64'(timeout_err), 64'd1);
    run_bursts(a, frame_words);
    chk("timeout_sticky", 64'(timeout_err), 64'd1);

    // Zero-length frame never requests.
    frame_words = 27'd0;
    pulse_start();
    a = model_restart(frame_base, frame_words);
    #2; r0 = req_rises;
    repeat (1000) @(negedge mem_clk);
    #2;
    chk("zero_no_req", 64'(req_rises - r0), 64'd0);
    chk("zero_no_done", 64'(done_cnt), 64'(exp_done));

    // Two consecutive frames at base 0 (buffer alternation when enabled).
    frame_base = 27'd0; frame_words = 27'd256;
    push_words(512);
    pulse_start();
    a = model_restart(frame_base, frame_words);
    run_bursts(a, frame_words);
    pulse_start();
    a = model_restart(frame_base, frame_words);
    run_bursts(a, frame_words);

    // Asynchronous reset in the middle of a burst clears every output.
    frame_base = 27'($urandom); frame_words = 27'd128;
    push_words(128);
    pulse_start();
    wait_req(50, ok);
    chk("mid_req_seen", 64'(ok), 64'd1);
    bus.wr_burst_data_req = 1'b1;
    repeat (3) @(negedge mem_clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(bus.wr_burst_req), 64'd0);
    chk("mid_rst_addr_len", 64'({bus.wr_burst_addr, bus.wr_burst_len}), 64'd0);
    chk("mid_rst_data", 64'(bus.wr_burst_data), 64'd0);
    chk("mid_rst_flags", 64'({fifo_rd_en, frame_done, timeout_err, frame_bank}), 64'd0);
    bus.wr_burst_data_req = 1'b0;
    repeat (2) @(negedge mem_clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_burst_writer.md
Name: frame_burst_writer

Overview:
- Single write channel feeding one input port (ch0..ch3) of the 4-channel round-robin DDR write arbiter.
- Drains a show-ahead pixel FIFO in fixed-length bursts into a linear frame region of memory.
- Generates burst address and length, and restarts at the frame base on each frame-start event from the video domain.
- Full-length bursts are issued until the frame tail, where a shorter final burst closes the frame.

Parameters:
- MEM_DATA_BITS, 32, width of the memory data word; must match the arbiter.
- BURST_LEN, 128, nominal burst length in words; range 1..1023.
- LEVEL_BITS, 11, width of the FIFO fill-level input.
- TIMEOUT, 10000, maximum cycles in WRITE without a finish before abort.

Ports:
- mem_clk  in  1  memory-side clock; all logic is synchronous to it.
- rst_n  in  1  asynchronous, active-low reset.
- frame_base  in  27  word address of frame start; sampled at each frame restart.
- frame_words  in  27  frame size in words; sampled at each frame restart; 0 means channel disabled.
- frame_start  in  1  level/pulse from the video domain (asynchronous); a rising edge restarts the frame.
- fifo_level  in  LEVEL_BITS  words available in the show-ahead FIFO.
- fifo_rdata  in  MEM_DATA_BITS  FIFO head word.
- fifo_rd_en  out  1  FIFO pop.
- wr_burst_req  out  1  to arbiter chN_wr_burst_req.
- wr_burst_len  out  10  to arbiter chN_wr_burst_len.
- wr_burst_addr  out  27  to arbiter chN_wr_burst_addr.
- wr_burst_data_req  in  1  from arbiter chN_wr_burst_data_req.
- wr_burst_data  out  MEM_DATA_BITS  to arbiter chN_wr_burst_data.
- wr_burst_finish  in  1  from arbiter chN_wr_burst_finish; a 1-cycle pulse.
- frame_done  out  1  1-cycle pulse when the last word of the frame has been accepted.
- timeout_err  out  1  sticky flag, cleared only by reset.
- frame_bank  out  1  active bank; see Optional Feature.

Behaviour:
- Reset values:
  - All outputs 0.
  - Internal address = 0; remaining = 0.
  - State IDLE.
- frame_start handling:
  - Passed through a 2-FF synchronizer, then a rising-edge detector; the edge sets a pending flag.
- Restart (pending flag applied):
  - Taken only in IDLE or CHECK, never mid-burst.
  - Actions: addr <= frame_base; remaining <= frame_words; clear pending.
- Burst sizing:
  - cur_len = min(BURST_LEN, remaining), truncated to 10 bits.
- State machine:
  - IDLE -> CHECK unconditionally; a restart may be applied here.
  - CHECK: if pending, apply restart and stay in CHECK.
    - Else if remaining != 0 and fifo_level >= cur_len: latch wr_burst_len = cur_len and wr_burst_addr = addr; -> REQ.
    - Otherwise stay.
  - REQ: assert wr_burst_req (registered, held high); -> WRITE.
  - WRITE:
    - wr_burst_data = fifo_rdata (combinational); fifo_rd_en = wr_burst_data_req (combinational).
    - On wr_burst_finish: deassert wr_burst_req on the next edge; -> END.
  - END:
    - addr <= addr + wr_burst_len, with 27-bit wrap, no saturation.
    - remaining <= remaining - wr_burst_len.
    - If the new remaining == 0, pulse frame_done.
    - -> CHECK.
- wr_burst_req stays high from REQ until the cycle after finish. The arbiter revisits this channel only after at least 4 cycles, so no duplicate grant occurs.
- Timeout:
  - Cycle counter runs in REQ/WRITE and clears in every other state.
  - When it reaches TIMEOUT: drop wr_burst_req, set timeout_err, -> CHECK with addr/remaining unchanged; the same burst is retried.
- Edge cases:
  - frame_words == 0: no requests are ever issued.
  - frame_start edge during WRITE: deferred until END has completed.
  - Two edges while pending: merged into one restart.
  - fifo_level is never assumed to decrease other than by pops.
- Asynchronous reset mid-burst returns all outputs to 0 immediately; the arbiter recovers via its own watchdog.

Optional Feature:
- Macro: FRAME_BURST_WRITER_PINGPONG_EN.
- Defined:
  - Each applied restart toggles frame_bank.
  - Restart address = frame_base + (frame_bank_new ? frame_words : 0), a 27-bit add.
  - frame_bank tells the read side which buffer is stable.
- Undefined:
  - frame_bank is tied to 0.
  - Restart address = frame_base.

Test Plan:
- Basic frame:
  - Stimulus: frame_base=0x1000, frame_words=300, BURST_LEN=128, FIFO preloaded with 300 words, one frame_start edge.
  - Expected: three bursts, addr 0x1000/0x1080/0x1100 with len 128/128/44; 300 pops total; frame_done pulses once after the third finish.
- Insufficient data:
  - Stimulus: fifo_level=100 with remaining=300.
  - Expected: no wr_burst_req. Raising the level to 128 produces the request within 3 cycles.
- Deferred restart:
  - Stimulus: frame_start edge mid-WRITE.
  - Expected: the current burst completes and addr advances. The next burst goes to frame_base with remaining=frame_words.
- Timeout:
  - Stimulus: grant withheld (no data_req/finish) for TIMEOUT cycles.
  - Expected: wr_burst_req drops, timeout_err=1, the same addr/len is re-requested, and the flag stays set.
- Zero-length frame:
  - Stimulus: frame_words=0, frame_start edge.
  - Expected: wr_burst_req stays 0 for 1000 cycles and frame_done never pulses.
- Ping-pong (macro defined):
  - Stimulus: frame_base=0, frame_words=256, two frames.
  - Expected: frame_bank goes 1 then 0. The first burst of frame 1 is at addr 256; the first burst of frame 2 is at addr 0.
